// File: rtl/mp64_mem_resp_pkg.sv
// mp64_mem_resp_pkg: bus size encodings, responder state type and lane helpers.
package mp64_mem_resp_pkg;
  localparam logic [1:0] BUS_BYTE  = 2'd0;
  localparam logic [1:0] BUS_HALF  = 2'd1;
  localparam logic [1:0] BUS_WORD  = 2'd2;
  localparam logic [1:0] BUS_DWORD = 2'd3;
  localparam int MEM_RESP_MAX_LATENCY = 15;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  function automatic logic [2:0] align_lane(input logic [1:0] size, input logic [2:0] lane);
    return lane & (3'b111 << size);
  endfunction
  function automatic logic [7:0] size_be(input logic [1:0] size);
    return size == BUS_BYTE ? 8'h01 : size == BUS_HALF ? 8'h03 : size == BUS_WORD ? 8'h0f : 8'hff;
  endfunction
  function automatic logic [63:0] be_to_bits(input logic [7:0] be);
    for (int i = 0; i < 8; i++) be_to_bits[8*i +: 8] = {8{be[i]}};
  endfunction
endpackage

// File: rtl/mp64_sram_be.sv
// mp64_sram_be: DEPTH_WORDS x 64 synchronous RAM with byte-enable write and registered read.
module mp64_sram_be #(
  parameter int DEPTH_WORDS = 8192,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [7:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/mp64_mem_resp.sv
// mp64_mem_resp: single-outstanding valid/ready memory responder with programmable latency.
module mp64_mem_resp
  import mp64_mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 8192,
  parameter int          LATENCY     = 1,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic [63:0] bus_addr,
  input  logic        bus_wen,
  input  logic [1:0]  bus_size,
  input  logic [63:0] bus_wdata,
  output logic [63:0] bus_rdata,
  output logic        bus_ready,
  output logic [63:0] stat_reads,
  output logic [63:0] stat_writes,
  output logic [63:0] stat_oor
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH_WORDS) * 64'd8;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d, r_idx;
  logic [2:0] lane_q, lane_d, r_lane, rlane_q, rlane_d;
  logic [1:0] size_q, size_d, r_size, rsize_q, rsize_d;
  logic wen_q, wen_d, r_wen, oor_q, oor_d, r_oor, rzero_q, rzero_d;
  logic [63:0] wdata_q, wdata_d, r_wdata;
  logic [63:0] reads_q, reads_d, writes_q, writes_d, oorc_q, oorc_d;
  logic [63:0] in_off, ram_wdata, ram_q;
  logic in_oor, accept, direct, go_resp, ram_we, ram_re;
  logic [7:0] ram_be;
  // In IDLE the request is taken straight from the bus so LATENCY=0 can hit the RAM at the accept edge.
  always_comb begin
    in_off    = bus_addr - BASE_ADDR;
    in_oor    = (bus_addr < BASE_ADDR) || (in_off >= MEM_BYTES);
    direct    = state_q == ST_IDLE;
    accept    = rst_n && direct && bus_valid;
    r_idx     = direct ? in_off[AW+2:3] : idx_q;
    r_lane    = direct ? align_lane(bus_size, in_off[2:0]) : lane_q;
    r_size    = direct ? bus_size : size_q;
    r_wen     = direct ? bus_wen : wen_q;
    r_oor     = direct ? in_oor : oor_q;
    r_wdata   = direct ? bus_wdata : wdata_q;
    go_resp   = accept ? LATENCY == 0 : state_q == ST_WAIT && cnt_q == 4'd1;
    state_d   = state_q == ST_RESP ? ST_IDLE : go_resp ? ST_RESP : accept ? ST_WAIT : state_q;
    cnt_d     = accept ? 4'(LATENCY) : state_q == ST_WAIT ? cnt_q - 4'd1 : cnt_q;
    idx_d     = accept ? r_idx : idx_q;
    lane_d    = accept ? r_lane : lane_q;
    size_d    = accept ? r_size : size_q;
    wen_d     = accept ? r_wen : wen_q;
    oor_d     = accept ? r_oor : oor_q;
    wdata_d   = accept ? r_wdata : wdata_q;
    rlane_d   = go_resp ? r_lane : rlane_q;
    rsize_d   = go_resp ? r_size : rsize_q;
    rzero_d   = go_resp ? r_wen || r_oor : rzero_q;
    reads_d   = reads_q + 64'(accept && !bus_wen);
    writes_d  = writes_q + 64'(accept && bus_wen);
    oorc_d    = oorc_q + 64'(accept && in_oor);
    ram_we    = go_resp && r_wen && !r_oor;
    ram_re    = go_resp && !r_wen && !r_oor;
    ram_be    = size_be(r_size) << r_lane;
    ram_wdata = r_wdata << {r_lane, 3'b000};
  end
  assign bus_ready   = state_q == ST_RESP;
  assign bus_rdata   = rzero_q ? 64'h0 : (ram_q >> {rlane_q, 3'b000}) & be_to_bits(size_be(rsize_q));
  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_oor    = oorc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      wen_q    <= 1'b0;
      oor_q    <= 1'b0;
      wdata_q  <= '0;
      rlane_q  <= '0;
      rsize_q  <= '0;
      rzero_q  <= 1'b1;
      reads_q  <= '0;
      writes_q <= '0;
      oorc_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      wen_q    <= wen_d;
      oor_q    <= oor_d;
      wdata_q  <= wdata_d;
      rlane_q  <= rlane_d;
      rsize_q  <= rsize_d;
      rzero_q  <= rzero_d;
      reads_q  <= reads_d;
      writes_q <= writes_d;
      oorc_q   <= oorc_d;
    end
  end
  mp64_sram_be #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .idx   (r_idx),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );
endmodule
